ysyx_25040109_ifetch_axi: RTL and testbench
===========================================

Name: ysyx_25040109_ifetch_axi

Overview:
- Instruction-fetch bus master for the multi-cycle NPC. It sits directly upstream of the IFU handshake stage.
- Holds the architectural fetch PC and issues one single-beat AXI4 read per instruction on the imem AR/R channels.
- Presents the returned word to the IFU as imem_rdata/mem_valid under a valid/ready handshake.
- Waits for the committed next PC from WBU before fetching again; at most one fetch is outstanding.

Parameters:
- RESET_PC, 32'h8000_0000, first fetch address after reset.
- ARID, 4'h0, AXI ID driven on every read; also the expected RID.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- npc_valid  in  1  WBU commit strobe; npc is valid this cycle
- npc  in  32  next PC from the committed instruction
- ifu_ready_to_mem  in  1  IFU can accept an instruction
- imem_rdata  out  32  fetched instruction to IFU
- mem_valid  out  1  imem_rdata valid to IFU
- fetch_err  out  1  qualifies imem_rdata: bus error, RID mismatch or misaligned PC
- fetch_pc  out  32  PC of the current or pending fetch
- imem_araddr  out  32  read address
- imem_arvalid  out  1  read address valid
- imem_arready  in  1  slave accepts address
- imem_arid  out  4  constant ARID
- imem_arlen  out  8  constant 0 (single beat)
- imem_arsize  out  3  constant 3'b010 (4 bytes)
- imem_arburst  out  2  constant 2'b01 (INCR)
- imem_rvalid  in  1  read data valid
- imem_rready  out  1  master accepts read data
- imem_rdata_bus  in  32  read data
- imem_rresp  in  2  read response
- imem_rlast  in  1  last beat; must be 1
- imem_rid  in  4  read ID

Behaviour:
- Clock and reset: one clock (clock). Reset is synchronous and active-high.
- Reset values:
  - State is S_AR and fetch_pc = RESET_PC.
  - mem_valid=0, fetch_err=0, imem_rdata=0.
  - imem_rready=0.
  - imem_arvalid is decoded from state, so it is 1 in the first cycle after reset deasserts.
- States: S_AR, S_R, S_OUT, S_WAIT.
- S_AR:
  - imem_arvalid=1 and imem_araddr=fetch_pc, both held stable until the imem_arvalid&&imem_arready handshake.
  - On handshake go to S_R.
  - arvalid never drops before the handshake.
- S_R:
  - imem_rready=1.
  - On imem_rvalid, register imem_rdata_bus into imem_rdata.
  - Set fetch_err = (rresp!=2'b00) | (rid!=ARID) | !rlast.
  - Go to S_OUT.
- S_OUT:
  - mem_valid=1; imem_rdata and fetch_err held stable.
  - On mem_valid&&ifu_ready_to_mem, go to S_WAIT; mem_valid is 0 from the next cycle.
- S_WAIT:
  - On npc_valid, latch fetch_pc=npc.
  - If npc[1:0]!=0: no bus access; load imem_rdata=32'h0 and fetch_err=1; go to S_OUT next cycle.
  - Otherwise go to S_AR.
- npc_valid outside S_WAIT is ignored, including the same cycle as the S_OUT handshake.
- Latency:
  - AR handshake in cycle t, R handshake in cycle t+1: mem_valid rises at t+2.
  - Best case from npc_valid to mem_valid is 3 cycles.
- Backpressure:
  - Arbitrary arready/rvalid stall lengths must work with no data loss and no duplicate AR.
  - Arbitrary ifu_ready_to_mem stalls hold the output unchanged.
- A reset asserted in any state returns to the reset state next cycle. The slave shares the reset, so no stale R beat is expected afterwards.
- The address is never incremented internally; fetch_pc changes only on reset or npc latch.

Decomposition:
- Shared package holds:
  - state encoding (S_AR, S_R, S_OUT, S_WAIT)
  - AXI constants: RESP_OKAY=2'b00, SIZE_WORD=3'b010, BURST_INCR=2'b01, LEN_SINGLE=8'd0
- No sub-module: FSM, PC register and output register fit one file (~150 lines).

Test Plan:
- Reset release, arready=1, rvalid one cycle after AR, rdata_bus=32'h0000_0413, ifu_ready=1 -> araddr=32'h8000_0000; mem_valid=1 with imem_rdata=32'h0000_0413, fetch_err=0, two cycles after AR handshake.
- arready held low 5 cycles, then rvalid delayed 7 cycles -> exactly one AR handshake; araddr stable throughout; rready=1 only in S_R; single mem_valid pulse sequence.
- ifu_ready_to_mem=0 for 4 cycles in S_OUT -> mem_valid stays 1 and imem_rdata unchanged; the handshake on cycle 5 moves to S_WAIT; npc_valid asserted during the stall is ignored.
- npc_valid with npc=32'h8000_0010 in S_WAIT -> next araddr=32'h8000_0010, fetch_pc=32'h8000_0010.
- rresp=2'b10 -> fetch_err=1 with the data delivered.
- rid=4'h3 -> fetch_err=1.
- npc=32'h8000_0002 -> no arvalid; mem_valid=1, imem_rdata=0, fetch_err=1.
- Reset asserted in S_R with rvalid low -> next cycle arvalid=1 with araddr=32'h8000_0000, mem_valid=0.

Source files
------------

// File: rtl/ysyx_25040109_ifetch_axi_pkg.sv
// Shared definitions for the instruction-fetch AXI master: FSM encoding and
// the fixed AXI read-channel attributes it drives.
package ysyx_25040109_ifetch_axi_pkg;

    typedef enum logic [1:0] {
        S_AR   = 2'd0,
        S_R    = 2'd1,
        S_OUT  = 2'd2,
        S_WAIT = 2'd3
    } fetch_state_t;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [2:0] SIZE_WORD  = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [7:0] LEN_SINGLE = 8'd0;

    function automatic logic word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_25040109_ifetch_axi.sv
// Instruction-fetch bus master: one single-beat AXI4 read per instruction,
// result handed to the IFU under valid/ready, next PC taken from WBU commit.
module ysyx_25040109_ifetch_axi
    import ysyx_25040109_ifetch_axi_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [3:0]  ARID     = 4'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        npc_valid,
    input  logic [31:0] npc,
    input  logic        ifu_ready_to_mem,
    output logic [31:0] imem_rdata,
    output logic        mem_valid,
    output logic        fetch_err,
    output logic [31:0] fetch_pc,
    output logic [31:0] imem_araddr,
    output logic        imem_arvalid,
    input  logic        imem_arready,
    output logic [3:0]  imem_arid,
    output logic [7:0]  imem_arlen,
    output logic [2:0]  imem_arsize,
    output logic [1:0]  imem_arburst,
    input  logic        imem_rvalid,
    output logic        imem_rready,
    input  logic [31:0] imem_rdata_bus,
    input  logic [1:0]  imem_rresp,
    input  logic        imem_rlast,
    input  logic [3:0]  imem_rid
);

    fetch_state_t state_reg;
    logic [31:0]  fetch_pc_reg;
    logic [31:0]  rdata_reg;
    logic         err_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= S_AR;
            fetch_pc_reg <= RESET_PC;
            rdata_reg    <= 32'h0;
            err_reg      <= 1'b0;
        end else begin
            case (state_reg)
                S_AR: begin
                    if (imem_arready) begin
                        state_reg <= S_R;
                    end
                end
                S_R: begin
                    if (imem_rvalid) begin
                        rdata_reg <= imem_rdata_bus;
                        err_reg   <= (imem_rresp != RESP_OKAY) | (imem_rid != ARID) | ~imem_rlast;
                        state_reg <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (ifu_ready_to_mem) begin
                        state_reg <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (npc_valid) begin
                        fetch_pc_reg <= npc;
                        // A misaligned target never reaches the bus; report it as a faulted fetch.
                        if (!word_aligned(npc)) begin
                            rdata_reg <= 32'h0;
                            err_reg   <= 1'b1;
                            state_reg <= S_OUT;
                        end else begin
                            state_reg <= S_AR;
                        end
                    end
                end
                default: state_reg <= S_AR;
            endcase
        end
    end

    assign imem_arvalid = (state_reg == S_AR);
    assign imem_rready  = (state_reg == S_R);
    assign mem_valid    = (state_reg == S_OUT);
    assign imem_araddr  = fetch_pc_reg;
    assign fetch_pc     = fetch_pc_reg;
    assign imem_rdata   = rdata_reg;
    assign fetch_err    = err_reg;

    assign imem_arid    = ARID;
    assign imem_arlen   = LEN_SINGLE;
    assign imem_arsize  = SIZE_WORD;
    assign imem_arburst = BURST_INCR;

endmodule

// File: tb/tb_ysyx_25040109_ifetch_axi.sv
// Scoreboard bench for the fetch master: a directed slave/WBU driver pushes
// expected AR addresses and IFU deliveries; a monitor checks every handshake.
module tb_ysyx_25040109_ifetch_axi;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        npc_valid;
    logic [31:0] npc;
    logic        ifu_ready_to_mem;
    logic [31:0] imem_rdata;
    logic        mem_valid;
    logic        fetch_err;
    logic [31:0] fetch_pc;
    logic [31:0] imem_araddr;
    logic        imem_arvalid;
    logic        imem_arready;
    logic [3:0]  imem_arid;
    logic [7:0]  imem_arlen;
    logic [2:0]  imem_arsize;
    logic [1:0]  imem_arburst;
    logic        imem_rvalid;
    logic        imem_rready;
    logic [31:0] imem_rdata_bus;
    logic [1:0]  imem_rresp;
    logic        imem_rlast;
    logic [3:0]  imem_rid;

    always #5 clock = ~clock;

    ysyx_25040109_ifetch_axi #(.RESET_PC(RESET_PC), .ARID(4'h0)) dut (
        .clock            (clock),
        .reset            (reset),
        .npc_valid        (npc_valid),
        .npc              (npc),
        .ifu_ready_to_mem (ifu_ready_to_mem),
        .imem_rdata       (imem_rdata),
        .mem_valid        (mem_valid),
        .fetch_err        (fetch_err),
        .fetch_pc         (fetch_pc),
        .imem_araddr      (imem_araddr),
        .imem_arvalid     (imem_arvalid),
        .imem_arready     (imem_arready),
        .imem_arid        (imem_arid),
        .imem_arlen       (imem_arlen),
        .imem_arsize      (imem_arsize),
        .imem_arburst     (imem_arburst),
        .imem_rvalid      (imem_rvalid),
        .imem_rready      (imem_rready),
        .imem_rdata_bus   (imem_rdata_bus),
        .imem_rresp       (imem_rresp),
        .imem_rlast       (imem_rlast),
        .imem_rid         (imem_rid)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        err;
    } exp_t;

    // mode: 0 normal fetch, 1 misaligned npc, 2 reset during S_R
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        logic [3:0]  rid;
        logic        rlast;
        int          ar_dly;
        int          r_dly;
        int          stall;
        logic        exp_err;
        logic        use_npc;
        int          mode;
    } vec_t;

    logic [31:0] exp_ar_q[$];
    exp_t        exp_out_q[$];
    vec_t        vecs[8];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    // Monitor: compares every AR and IFU handshake against the scoreboard.
    logic        prev_arvalid, prev_arready, prev_mv, prev_rdy, prev_reset;
    logic [31:0] prev_araddr, prev_rdata;
    initial begin
        prev_arvalid = 0; prev_arready = 0; prev_mv = 0; prev_rdy = 0; prev_reset = 1;
        prev_araddr = 0; prev_rdata = 0;
    end

    always @(negedge clock) begin
        if (!reset && !prev_reset) begin
            if (prev_arvalid && !prev_arready) begin
                check("ar_hold_valid", {31'd0, imem_arvalid}, 32'd1);
                check("ar_hold_addr", imem_araddr, prev_araddr);
            end
            if (prev_mv && !prev_rdy) begin
                check("out_hold_valid", {31'd0, mem_valid}, 32'd1);
                check("out_hold_rdata", imem_rdata, prev_rdata);
            end
            if (imem_rready && (imem_arvalid || mem_valid)) begin
                check("rready_only_in_r", {31'd0, imem_rready}, 32'd0);
            end
            if (imem_arvalid && imem_arready) begin
                $display("AR  addr=%h", imem_araddr);
                if (exp_ar_q.size() == 0) begin
                    check("unexpected_ar", imem_araddr, 32'hxxxx_xxxx);
                end else begin
                    check("ar_addr", imem_araddr, exp_ar_q.pop_front());
                end
                check("ar_attrs", {16'd0, imem_arid, imem_arlen, imem_arsize, imem_arburst},
                      {16'd0, 4'h0, 8'd0, 3'b010, 2'b01});
            end
            if (mem_valid && ifu_ready_to_mem) begin
                $display("OUT pc=%h rdata=%h err=%0d", fetch_pc, imem_rdata, fetch_err);
                if (exp_out_q.size() == 0) begin
                    check("unexpected_out", imem_rdata, 32'hxxxx_xxxx);
                end else begin
                    exp_t e;
                    e = exp_out_q.pop_front();
                    check("out_rdata", imem_rdata, e.data);
                    check("out_err", {31'd0, fetch_err}, {31'd0, e.err});
                    check("out_pc", fetch_pc, e.pc);
                end
            end
        end
        prev_arvalid = imem_arvalid;
        prev_arready = imem_arready;
        prev_araddr  = imem_araddr;
        prev_mv      = mem_valid;
        prev_rdy     = ifu_ready_to_mem;
        prev_rdata   = imem_rdata;
        prev_reset   = reset;
    end

    task automatic wait_arvalid(output logic ok);
        int n = 0;
        ok = 1'b1;
        while (!imem_arvalid) begin
            step();
            n++;
            if (n > 50) begin
                check("arvalid_timeout", 32'd0, 32'd1);
                ok = 1'b0;
                return;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic ok;
        exp_t e;
        if (v.use_npc) begin
            npc = v.addr;
            npc_valid = 1'b1;
            step();
            npc_valid = 1'b0;
            npc = 32'h0;
        end
        if (v.mode == 1) begin
            e.pc = v.addr; e.data = 32'h0; e.err = 1'b1;
            exp_out_q.push_back(e);
            check("misalign_mem_valid", {31'd0, mem_valid}, 32'd1);
            check("misalign_no_ar", {31'd0, imem_arvalid}, 32'd0);
            ifu_ready_to_mem = 1'b1;
            step();
            ifu_ready_to_mem = 1'b0;
            return;
        end
        exp_ar_q.push_back(v.addr);
        wait_arvalid(ok);
        if (!ok) return;
        check("fetch_pc_pending", fetch_pc, v.addr);
        for (int i = 0; i < v.ar_dly; i++) step();
        imem_arready = 1'b1;
        step();
        imem_arready = 1'b0;
        for (int i = 0; i < v.r_dly; i++) step();
        check("rready_in_r", {31'd0, imem_rready}, 32'd1);
        if (v.mode == 2) begin
            reset = 1'b1;
            step();
            reset = 1'b0;
            check("rst_arvalid", {31'd0, imem_arvalid}, 32'd1);
            check("rst_araddr", imem_araddr, RESET_PC);
            check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
            return;
        end
        e.pc = v.addr; e.data = v.data; e.err = v.exp_err;
        exp_out_q.push_back(e);
        imem_rdata_bus = v.data;
        imem_rresp = v.resp;
        imem_rid = v.rid;
        imem_rlast = v.rlast;
        imem_rvalid = 1'b1;
        step();
        imem_rvalid = 1'b0;
        imem_rdata_bus = 32'h0; imem_rresp = 2'b00; imem_rid = 4'h0; imem_rlast = 1'b1;
        check("latency_mem_valid", {31'd0, mem_valid}, 32'd1);
        for (int i = 0; i < v.stall; i++) begin
            npc = 32'h1234_5678;
            npc_valid = 1'b1;
            step();
        end
        ifu_ready_to_mem = 1'b1;
        step();
        ifu_ready_to_mem = 1'b0;
        npc_valid = 1'b0;
        npc = 32'h0;
        check("mem_valid_drop", {31'd0, mem_valid}, 32'd0);
        check("fetch_pc_hold", fetch_pc, v.addr);
    endtask

    initial begin
        reset = 1'b1; npc_valid = 1'b0; npc = 32'h0; ifu_ready_to_mem = 1'b0;
        imem_arready = 1'b0; imem_rvalid = 1'b0; imem_rdata_bus = 32'h0;
        imem_rresp = 2'b00; imem_rlast = 1'b1; imem_rid = 4'h0;

        //          addr           data           resp   rid   rlast ard rd stall err   npc  mode
        vecs[0] = '{32'h8000_0000, 32'h0000_0413, 2'b00, 4'h0, 1'b1, 0, 0, 0, 1'b0, 1'b0, 0};
        vecs[1] = '{32'h8000_0010, 32'h00a0_0093, 2'b00, 4'h0, 1'b1, 5, 7, 4, 1'b0, 1'b1, 0};
        vecs[2] = '{32'h8000_0014, 32'hdead_beef, 2'b10, 4'h0, 1'b1, 1, 0, 0, 1'b1, 1'b1, 0};
        vecs[3] = '{32'h8000_0018, 32'h0010_0073, 2'b00, 4'h3, 1'b1, 0, 2, 1, 1'b1, 1'b1, 0};
        vecs[4] = '{32'h8000_001c, 32'h0000_0013, 2'b00, 4'h0, 1'b0, 0, 0, 0, 1'b1, 1'b1, 0};
        vecs[5] = '{32'h8000_0002, 32'h0000_0000, 2'b00, 4'h0, 1'b1, 0, 0, 0, 1'b1, 1'b1, 1};
        vecs[6] = '{32'h8000_0020, 32'h0000_0000, 2'b00, 4'h0, 1'b1, 0, 1, 0, 1'b0, 1'b1, 2};
        vecs[7] = '{32'h8000_0000, 32'h0050_0113, 2'b00, 4'h0, 1'b1, 2, 3, 2, 1'b0, 1'b0, 0};

        repeat (3) step();
        check("rst_mem_valid0", {31'd0, mem_valid}, 32'd0);
        check("rst_rready0", {31'd0, imem_rready}, 32'd0);
        check("rst_fetch_err0", {31'd0, fetch_err}, 32'd0);
        check("rst_rdata0", imem_rdata, 32'h0);
        check("rst_fetch_pc0", fetch_pc, RESET_PC);
        reset = 1'b0;
        step();
        check("first_arvalid", {31'd0, imem_arvalid}, 32'd1);

        for (int k = 0; k < 8; k++) run_vec(vecs[k]);

        repeat (4) step();
        check("ar_queue_empty", exp_ar_q.size(), 32'd0);
        check("out_queue_empty", exp_out_q.size(), 32'd0);
        check("idle_no_arvalid", {31'd0, imem_arvalid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
